// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped write-through L1 data cache, 8-byte lines, 32-bit memory beats.
// Define DCACHE_WR_UPDATE_EN to merge store bytes into hitting lines; otherwise stores invalidate them.
module dcache_wt #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_address,
  output logic                  rd_dp_valid,
  input  logic                  rd_dp_ready,
  output logic [63:0]           rd_dp_read_data,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_address,
  input  logic [63:0]           wr_req_data,
  input  logic [3:0]            wr_req_size,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_wr,
  output logic [31:0]           mem_wr_data,
  output logic [3:0]            mem_wr_be,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_data_valid,
  output logic                  busy
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int LW    = ADDR_WIDTH - 3;
  localparam int TW    = LW - INDEX_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL0, FILL1, WBEAT, WUPD, RESP} state_t;

  state_t                  state_r;
  logic                    init_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    phase_r;
  logic                    need_b_r;
  logic                    two_lines_r;
  logic [1:0]              beat_r;
  logic [1:0]              last_beat_r;
  logic [63:0]             stage_a_r;
  logic [31:0]             fill_lo_r;
  logic [15:0]             wmask_r;
  logic [127:0]            wwin_r;
  logic [LINES-1:0]        valid_r;
  logic [63:0]             data_mem [LINES];
  logic [TW-1:0]           tag_mem [LINES];

  logic                    mem_req_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic                    mem_rd_wr_r;
  logic [31:0]             mem_wr_data_r;
  logic [3:0]              mem_wr_be_r;
  logic                    rd_dp_valid_r;
  logic [63:0]             rd_data_r;

  logic [LW-1:0]           cur_line_s;
  logic [INDEX_BITS-1:0]   cur_idx_s;
  logic [TW-1:0]           cur_tag_s;
  logic [63:0]             line_data_s;
  logic                    hit_s;
  logic [1:0]              beat_word_s;
  logic [3:0]              beat_be_s;
  logic [31:0]             beat_data_s;
  logic [ADDR_WIDTH-1:0]   beat_addr_s;
  logic [3:0]              size_n_s;
  logic [15:0]             wmask_n_s;
  logic [127:0]            wwin_n_s;
  logic [3:0]              beat_span_s;
  logic [3:0]              line_span_s;
  logic                    fill_we_s;

  // Pick the 8 result bytes out of the two-line window starting at the byte offset.
  function automatic logic [63:0] line_extract(input logic [127:0] pair, input logic [2:0] off);
    line_extract = pair[{off, 3'b000} +: 64];
  endfunction

  // Current-line lookup, write-beat decode and store window built from the incoming request.
  always_comb begin
    cur_line_s  = addr_r[ADDR_WIDTH-1:3] + {{(LW-1){1'b0}}, phase_r};
    cur_idx_s   = cur_line_s[INDEX_BITS-1:0];
    cur_tag_s   = cur_line_s[LW-1:INDEX_BITS];
    line_data_s = data_mem[cur_idx_s];
    hit_s       = valid_r[cur_idx_s] && (tag_mem[cur_idx_s] == cur_tag_s);
    // The store window is 16 bytes aligned to line A; beats index its 32-bit words.
    beat_word_s = {1'b0, addr_r[2]} + beat_r;
    beat_be_s   = wmask_r[{beat_word_s, 2'b00} +: 4];
    beat_data_s = wwin_r[{beat_word_s, 5'b00000} +: 32];
    beat_addr_s = {addr_r[ADDR_WIDTH-1:2] + {{(ADDR_WIDTH-4){1'b0}}, beat_r}, 2'b00};
    size_n_s    = ((wr_req_size == 4'd0) || (wr_req_size > 4'd8)) ? 4'd8 : wr_req_size;
    wmask_n_s   = ((16'd1 << size_n_s) - 16'd1) << wr_req_address[2:0];
    wwin_n_s    = {64'd0, wr_req_data} << {wr_req_address[2:0], 3'b000};
    beat_span_s = {2'b00, wr_req_address[1:0]} + size_n_s - 4'd1;
    line_span_s = {1'b0, wr_req_address[2:0]} + size_n_s - 4'd1;
    fill_we_s   = (state_r == FILL1) && mem_req_r && mem_data_valid;
  end

`ifdef DCACHE_WR_UPDATE_EN
  logic [7:0]  lmask_s;
  logic [63:0] ldata_s;
  logic [63:0] merged_s;
  logic        upd_we_s;

  // Byte merge of the store window into the line currently addressed in WUPD.
  always_comb begin
    lmask_s  = wmask_r[{phase_r, 3'b000} +: 8];
    ldata_s  = wwin_r[{phase_r, 6'b000000} +: 64];
    merged_s = line_data_s;
    upd_we_s = (state_r == WUPD) && hit_s;
    for (int i = 0; i < 8; i++) begin
      if (lmask_s[i]) begin
        merged_s[8*i +: 8] = ldata_s[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = line_data_s[8*i +: 8];
      end
    end
  end
`endif

  // Line storage: fills install data and tag; store hits merge bytes when enabled.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      data_mem[cur_idx_s] <= {mem_rd_data, fill_lo_r};
      tag_mem[cur_idx_s]  <= cur_tag_s;
    end
`ifdef DCACHE_WR_UPDATE_EN
    else if (upd_we_s) begin
      data_mem[cur_idx_s] <= merged_s;
    end
`endif
  end

  // Control FSM with registered memory-port and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      init_r        <= 1'b0;
      addr_r        <= '0;
      phase_r       <= 1'b0;
      need_b_r      <= 1'b0;
      two_lines_r   <= 1'b0;
      beat_r        <= 2'd0;
      last_beat_r   <= 2'd0;
      stage_a_r     <= 64'd0;
      fill_lo_r     <= 32'd0;
      wmask_r       <= 16'd0;
      wwin_r        <= 128'd0;
      valid_r       <= '0;
      mem_req_r     <= 1'b0;
      mem_addr_r    <= '0;
      mem_rd_wr_r   <= 1'b0;
      mem_wr_data_r <= 32'd0;
      mem_wr_be_r   <= 4'd0;
      rd_dp_valid_r <= 1'b0;
      rd_data_r     <= 64'd0;
    end else begin
      init_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (init_r && wr_req_valid) begin
            addr_r      <= wr_req_address;
            wmask_r     <= wmask_n_s;
            wwin_r      <= wwin_n_s;
            last_beat_r <= beat_span_s[3:2];
            two_lines_r <= line_span_s[3];
            beat_r      <= 2'd0;
            phase_r     <= 1'b0;
            state_r     <= WBEAT;
          end else if (init_r && rd_req_valid) begin
            addr_r   <= rd_req_address;
            need_b_r <= |rd_req_address[2:0];
            phase_r  <= 1'b0;
            state_r  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!hit_s) begin
            state_r <= FILL0;
          end else if (!phase_r) begin
            stage_a_r <= line_data_s;
            if (need_b_r) begin
              phase_r <= 1'b1;
            end else begin
              rd_data_r     <= line_data_s;
              rd_dp_valid_r <= 1'b1;
              state_r       <= RESP;
            end
          end else begin
            rd_data_r     <= line_extract({line_data_s, stage_a_r}, addr_r[2:0]);
            rd_dp_valid_r <= 1'b1;
            state_r       <= RESP;
          end
        end
        FILL0, FILL1: begin
          // Each beat: first cycle sets up the request, then wait for completion.
          if (!mem_req_r) begin
            mem_req_r     <= 1'b1;
            mem_addr_r    <= {cur_line_s, (state_r == FILL1), 2'b00};
            mem_rd_wr_r   <= 1'b0;
            mem_wr_data_r <= 32'd0;
            mem_wr_be_r   <= 4'd0;
          end else if (mem_data_valid) begin
            mem_req_r <= 1'b0;
            if (state_r == FILL0) begin
              fill_lo_r <= mem_rd_data;
              state_r   <= FILL1;
            end else begin
              valid_r[cur_idx_s] <= 1'b1;
              state_r            <= LOOKUP;
            end
          end
        end
        WBEAT: begin
          if (!mem_req_r) begin
            mem_req_r     <= 1'b1;
            mem_addr_r    <= beat_addr_s;
            mem_rd_wr_r   <= 1'b1;
            mem_wr_data_r <= beat_data_s;
            mem_wr_be_r   <= beat_be_s;
          end else if (mem_data_valid) begin
            mem_req_r <= 1'b0;
            if (beat_r == last_beat_r) begin
              state_r <= WUPD;
            end else begin
              beat_r <= beat_r + 2'd1;
            end
          end
        end
        WUPD: begin
`ifndef DCACHE_WR_UPDATE_EN
          if (hit_s) begin
            valid_r[cur_idx_s] <= 1'b0;
          end
`endif
          if (two_lines_r && !phase_r) begin
            phase_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RESP: begin
          if (rd_dp_ready) begin
            rd_dp_valid_r <= 1'b0;
            state_r       <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign rd_req_ready    = (state_r == IDLE) && init_r;
  assign wr_req_ready    = (state_r == IDLE) && init_r;
  assign busy            = (state_r != IDLE);
  assign rd_dp_valid     = rd_dp_valid_r;
  assign rd_dp_read_data = rd_data_r;
  assign mem_req         = mem_req_r;
  assign mem_addr        = mem_addr_r;
  assign mem_rd_wr       = mem_rd_wr_r;
  assign mem_wr_data     = mem_wr_data_r;
  assign mem_wr_be       = mem_wr_be_r;

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: memory model responder, expected reads queued at acceptance.
module tb_dcache_wt;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req_valid, rd_req_ready, rd_dp_valid, rd_dp_ready;
  logic [31:0] rd_req_address;
  logic [63:0] rd_dp_read_data;
  logic        wr_req_valid, wr_req_ready;
  logic [31:0] wr_req_address;
  logic [63:0] wr_req_data;
  logic [3:0]  wr_req_size;
  logic        mem_req, mem_rd_wr, mem_data_valid, busy;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_wr_be;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  beat_t       beats_q[$];
  logic [63:0] exp_q[$];
  bit [31:0]   mem_m [bit [31:0]];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          stall_hi = 1'b0;
  int          dly = 0;

  dcache_wt #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_address(rd_req_address),
    .rd_dp_valid(rd_dp_valid), .rd_dp_ready(rd_dp_ready), .rd_dp_read_data(rd_dp_read_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_address(wr_req_address),
    .wr_req_data(wr_req_data), .wr_req_size(wr_req_size),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rd_wr(mem_rd_wr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .mem_rd_data(mem_rd_data), .mem_data_valid(mem_data_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] rdw(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_m.exists(w)) return mem_m[w];
    return w ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [63:0] exp_read(input logic [31:0] a);
    logic [63:0] r;
    logic [31:0] b;
    logic [31:0] w;
    r = 64'd0;
    for (int i = 0; i < 8; i++) begin
      b = a + 32'(i);
      w = rdw(b);
      r[8*i +: 8] = w[8*b[1:0] +: 8];
    end
    return r;
  endfunction

  // Memory responder: random 0-2 cycle latency, applies write beats to the model.
  initial begin
    logic [31:0] w;
    mem_data_valid = 1'b0;
    mem_rd_data = 32'd0;
    forever begin
      @(negedge clk);
      if (reset || mem_data_valid) begin
        mem_data_valid = 1'b0;
        dly = $urandom_range(0, 2);
      end else if (mem_req && !(stall_hi && mem_addr[2])) begin
        if (dly > 0) begin
          dly--;
        end else begin
          mem_data_valid = 1'b1;
          beats_q.push_back('{mem_addr, mem_rd_wr, mem_wr_data, mem_wr_be});
          if (mem_rd_wr) begin
            w = rdw(mem_addr);
            for (int i = 0; i < 4; i++) if (mem_wr_be[i]) w[8*i +: 8] = mem_wr_data[8*i +: 8];
            mem_m[mem_addr] = w;
          end else begin
            mem_rd_data = rdw(mem_addr);
          end
        end
      end
    end
  end

  // Called at a negedge: present the read, wait for acceptance, queue its expected data.
  task automatic start_read(input logic [31:0] a);
    int t;
    t = 0;
    rd_req_address = a;
    rd_req_valid = 1'b1;
    while (!(rd_req_ready && !wr_req_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_val("rd_accept", {63'd0, rd_req_ready}, 64'd1);
    exp_q.push_back(exp_read(a));
    @(posedge clk);
    #1 rd_req_valid = 1'b0;
  endtask

  task automatic finish_read(output int lat, output logic [63:0] d);
    logic [63:0] e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rd_dp_valid && lat < 500);
    check_val("rd_dp_valid", {63'd0, rd_dp_valid}, 64'd1);
    d = rd_dp_read_data;
    e = exp_q.pop_front();
    check_val("rd_data", d, e);
    rd_dp_ready = 1'b1;
    @(posedge clk);
    #1 rd_dp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output int lat, output logic [63:0] d);
    @(negedge clk);
    start_read(a);
    finish_read(lat, d);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [3:0] sz);
    int t;
    @(negedge clk);
    wr_req_address = a;
    wr_req_data = d;
    wr_req_size = sz;
    wr_req_valid = 1'b1;
    t = 0;
    while (!wr_req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 wr_req_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 500);
    check_val("wr_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_beat(input string tag, input int k, input logic [31:0] a,
                            input logic rw, input logic [3:0] be);
    if (beats_q.size() > k) begin
      check_val({tag, "_addr"}, {32'd0, beats_q[k].addr}, {32'd0, a});
      check_val({tag, "_rw"}, {63'd0, beats_q[k].rw}, {63'd0, rw});
      check_val({tag, "_be"}, {60'd0, beats_q[k].be}, {60'd0, be});
    end else begin
      check_val({tag, "_missing"}, 64'(beats_q.size()), 64'(k + 1));
    end
  endtask

  initial begin
    int t;
    int lat;
    logic [63:0] d;
    rd_req_valid = 1'b0; rd_req_address = 32'd0; rd_dp_ready = 1'b0;
    wr_req_valid = 1'b0; wr_req_address = 32'd0; wr_req_data = 64'd0; wr_req_size = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_rd_ready", {63'd0, rd_req_ready}, 64'd0);
    check_val("rst_wr_ready", {63'd0, wr_req_ready}, 64'd0);
    check_val("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_dp_valid", {63'd0, rd_dp_valid}, 64'd0);
    check_val("rst_dp_data", rd_dp_read_data, 64'd0);
    check_val("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check_val("rst_mem_be", {60'd0, mem_wr_be}, 64'd0);
    check_val("rst_mem_rw", {63'd0, mem_rd_wr}, 64'd0);
    check_val("rst_mem_wdata", {32'd0, mem_wr_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("rel_rd_ready", {63'd0, rd_req_ready}, 64'd1);
    check_val("rel_wr_ready", {63'd0, wr_req_ready}, 64'd1);

    // Cold read then repeat hit
    mem_m[32'h100] = 32'h1122_3344;
    mem_m[32'h104] = 32'h5566_7788;
    beats_q.delete();
    do_read(32'h100, lat, d);
    check_val("cold_beats", 64'(beats_q.size()), 64'd2);
    check_beat("cold_b0", 0, 32'h100, 1'b0, 4'h0);
    check_beat("cold_b1", 1, 32'h104, 1'b0, 4'h0);
    check_val("cold_data", d, 64'h5566_7788_1122_3344);
    beats_q.delete();
    do_read(32'h100, lat, d);
    check_val("hit_beats", 64'(beats_q.size()), 64'd0);
    check_val("hit_latency", 64'(lat), 64'd2);
    check_val("hit_data", d, 64'h5566_7788_1122_3344);

    // Unaligned read with both lines cached
    do_reset();
    mem_m[32'h100] = 32'h0302_0100; mem_m[32'h104] = 32'h0706_0504;
    mem_m[32'h108] = 32'h0B0A_0908; mem_m[32'h10C] = 32'h0F0E_0D0C;
    do_read(32'h100, lat, d);
    do_read(32'h108, lat, d);
    beats_q.delete();
    do_read(32'h105, lat, d);
    check_val("unal_beats", 64'(beats_q.size()), 64'd0);
    check_val("unal_latency", 64'(lat), 64'd3);
    check_val("unal_data", d, 64'h0C0B_0A09_0807_0605);

    // Write-through of a line-crossing word store, then re-read
    do_reset();
    mem_m[32'h100] = 32'h0302_0100; mem_m[32'h104] = 32'h0000_0000;
    do_read(32'h100, lat, d);
    beats_q.delete();
    do_write(32'h103, 64'hAABB_CCDD, 4'd4);
    check_val("wr_beats", 64'(beats_q.size()), 64'd2);
    check_beat("wr_b0", 0, 32'h100, 1'b1, 4'b1000);
    check_beat("wr_b1", 1, 32'h104, 1'b1, 4'b0111);
    if (beats_q.size() == 2) begin
      check_val("wr_b0_data", {32'd0, beats_q[0].data}, 64'h0000_0000_DD00_0000);
      check_val("wr_b1_data", {32'd0, beats_q[1].data}, 64'h0000_0000_00AA_BBCC);
    end
    beats_q.delete();
    do_read(32'h100, lat, d);
    check_val("wr_read_data", d, 64'h00AA_BBCC_DD02_0100);
`ifdef DCACHE_WR_UPDATE_EN
    check_val("wr_read_beats", 64'(beats_q.size()), 64'd0);
`else
    check_val("wr_read_beats", 64'(beats_q.size()), 64'd2);
`endif

    // Size 0 (means 8) store spanning three words and two cached lines
    do_read(32'h108, lat, d);
    do_read(32'h110, lat, d);
    beats_q.delete();
    do_write(32'h10E, 64'h8877_6655_4433_2211, 4'd0);
    check_val("w3_beats", 64'(beats_q.size()), 64'd3);
    check_beat("w3_b0", 0, 32'h10C, 1'b1, 4'b1100);
    check_beat("w3_b1", 1, 32'h110, 1'b1, 4'b1111);
    check_beat("w3_b2", 2, 32'h114, 1'b1, 4'b0011);
    if (beats_q.size() == 3) begin
      check_val("w3_b0_data", {32'd0, beats_q[0].data}, 64'h0000_0000_2211_0000);
    end
    beats_q.delete();
    do_read(32'h10A, lat, d);
`ifdef DCACHE_WR_UPDATE_EN
    check_val("w3_read_beats", 64'(beats_q.size()), 64'd0);
`else
    check_val("w3_read_beats", 64'(beats_q.size()), 64'd4);
`endif

    // Address wrap-around for line B
    beats_q.delete();
    do_read(32'hFFFF_FFFC, lat, d);
    check_val("wrap_beats", 64'(beats_q.size()), 64'd4);
    check_beat("wrap_b2", 2, 32'h0000_0000, 1'b0, 4'h0);
    check_beat("wrap_b3", 3, 32'h0000_0004, 1'b0, 4'h0);

    // Simultaneous read and write requests: write first
    beats_q.delete();
    @(negedge clk);
    wr_req_address = 32'h40; wr_req_data = 64'h0123_4567_89AB_CDEF; wr_req_size = 4'd8;
    wr_req_valid = 1'b1;
    rd_req_address = 32'h40; rd_req_valid = 1'b1;
    check_val("both_rd_ready", {63'd0, rd_req_ready}, 64'd1);
    @(posedge clk);
    #1 wr_req_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 500);
    check_val("both_wr_done", {63'd0, busy}, 64'd0);
    check_val("both_wr_beats", 64'(beats_q.size()), 64'd2);
    check_beat("both_b0", 0, 32'h40, 1'b1, 4'hF);
    exp_q.push_back(exp_read(32'h40));
    @(posedge clk);
    #1 rd_req_valid = 1'b0;
    check_val("both_rd_taken", {63'd0, busy}, 64'd1);
    finish_read(lat, d);
    check_val("both_rd_data", d, 64'h0123_4567_89AB_CDEF);

    // Reset during FILL1 of line B
    do_read(32'h200, lat, d);
    stall_hi = 1'b1;
    @(negedge clk);
    rd_req_address = 32'h205; rd_req_valid = 1'b1;
    @(posedge clk);
    #1 rd_req_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(mem_req && mem_addr == 32'h20C) && t < 500);
    check_val("f1_reached", {63'd0, mem_req}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check_val("f1_rst_mem_req", {63'd0, mem_req}, 64'd0);
    check_val("f1_rst_busy", {63'd0, busy}, 64'd0);
    check_val("f1_rst_dp_valid", {63'd0, rd_dp_valid}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stall_hi = 1'b0;
    @(negedge clk);
    beats_q.delete();
    do_read(32'h200, lat, d);
    check_val("f1_refetch_beats", 64'(beats_q.size()), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/dcache_wt.md
# dcache_wt

Parametrised direct-mapped, write-through L1 data cache with 8-byte lines, a 32-bit memory port, and split handling of unaligned accesses that cross a line boundary. It sits between the load/store datapath and the shared memory interconnect, operates on physical addresses, and takes one read or one write request at a time. This generation adds a configurable depth, byte-granular writes of 1–8 bytes with per-beat byte enables, and coherent update of cached lines on write hits.

## Interface
- INDEX_BITS, 6, log2 of line count (lines = 2^INDEX_BITS); legal range 2–10.
- ADDR_WIDTH, 32, physical address width; tag width = ADDR_WIDTH-3-INDEX_BITS.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears state and all valid bits.
- rd_req_valid / rd_req_ready  in/out  1  read request handshake.
- rd_req_address  in  ADDR_WIDTH  byte address of an 8-byte little-endian read.
- rd_dp_valid / rd_dp_ready  out/in  1  read response handshake.
- rd_dp_read_data  out  64  read result; byte 0 = byte at rd_req_address.
- wr_req_valid / wr_req_ready  in/out  1  write request handshake.
- wr_req_address  in  ADDR_WIDTH  byte address of write.
- wr_req_data  in  64  write data, byte 0 = lowest address.
- wr_req_size  in  4  bytes to write, 1–8; 0 and 9–15 are treated as 8.
- mem_req  out  1  beat request; held until mem_data_valid.
- mem_addr  out  ADDR_WIDTH  word-aligned beat address (bits [1:0] = 0).
- mem_rd_wr  out  1  1 = write beat, 0 = read beat.
- mem_wr_data  out  32  write beat data, lane-aligned.
- mem_wr_be  out  4  write byte enables; 4'b0000 on reads.
- mem_rd_data  in  32  read beat data; sampled when mem_data_valid=1.
- mem_data_valid  in  1  completes the current beat.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, LOOKUP, FILL0, FILL1, WBEAT, WUPD, RESP.
- IDLE: rd_req_ready = wr_req_ready = 1. If both valids are high, the write is accepted and the read waits. Address, data and size are registered on acceptance.
- Read:
  - Line A = addr[AW-1:3]. Line B = A+1, computed modulo 2^ADDR_WIDTH; B is needed only if addr[2:0] != 0.
  - LOOKUP compares the tag and valid bit of the current line. On a hit, the line is copied to staging (A) or consumed directly (B). On a miss, go to FILL0.
  - FILL0 fetches the line base; FILL1 fetches base+4 (low word first). After FILL1 the line is written with valid=1 and the state returns to LOOKUP for the same line, which then hits.
  - Once A and, if needed, B are resolved, go to RESP. rd_dp_read_data = ({B,A} >> 8*addr[2:0])[63:0].
- Write (write-through, no allocate):
  - Touched words run from addr[AW-1:2] to (addr+size-1)[AW-1:2] modulo 2^AW: 1–3 beats.
  - WBEAT issues each beat in ascending order with lane-shifted data and a byte-enable mask.
  - After the last beat, WUPD handles each touched line in one cycle per line: a hitting line has its enabled bytes merged in; a missing line is left unchanged. Then return to IDLE.
- RESP: rd_dp_valid=1 and the data is held until rd_dp_ready. Return to IDLE on the handshake.
- No requests are accepted outside IDLE.

## Timing
- Reset values: rd_req_ready=0 during reset, then 1 in the first cycle after release. wr_req_ready=0 in reset, then 1 in the first cycle after release. rd_dp_valid=0, mem_req=0, mem_rd_wr=0, mem_wr_be=0, mem_addr=0, mem_wr_data=0, rd_dp_read_data=0, busy=0, and all valid bits=0.
- Read hits, with acceptance at cycle 0:
  - Aligned hit: rd_dp_valid at cycle 2.
  - Unaligned, both lines hit: rd_dp_valid at cycle 3.
- Each miss adds 2 beats plus 1 cycle. A beat takes at least 1 cycle: mem_req is asserted in the cycle after entering the state and completes on the cycle mem_data_valid=1.
- mem_addr, mem_rd_wr, mem_wr_data and mem_wr_be are stable while mem_req=1.
- mem_data_valid is ignored while mem_req=0.
- Reset mid-operation drops mem_req and rd_dp_valid immediately (asynchronously). An in-flight beat is abandoned and the state returns to IDLE.

## Configuration
- DCACHE_WR_UPDATE_EN defined: WUPD merges write bytes into hitting lines (as above).
- DCACHE_WR_UPDATE_EN undefined: WUPD clears the valid bit of each touched line that hits. No data array write occurs on stores, and a subsequent read misses and refetches.

## Test plan
- Cold read of 0x00000100 with memory returning 0x11223344 then 0x55667788: the bench sees 2 read beats at 0x100 and 0x104, and the response is 0x5566778811223344. A repeat read of 0x100 produces no mem_req, with rd_dp_valid 2 cycles after acceptance.
- Unaligned read at 0x00000105 with both lines cached (data 0x0706050403020100 at 0x100 and 0x0F0E0D0C0B0A0908 at 0x108): the response is 0x0C0B0A0908070605 at cycle 3.
- Write of size 4, data 0xAABBCCDD, to 0x00000103 with line 0x100 cached: beat 0x100 has be=4'b1000 and data 0xDD000000; beat 0x104 has be=4'b0111 and data 0x00AABBCC. A subsequent read of 0x100 with no mem_req returns 0x00AABBCCDD020100 (macro defined). With the macro undefined, the read refetches the line.
- Wrap-around read at 0xFFFFFFFC (ADDR_WIDTH=32): the line B fill beats go to 0x00000000 and 0x00000004.
- rd_req_valid and wr_req_valid both asserted in IDLE: the write is accepted first, and the read is accepted in the first IDLE cycle after the write completes.
- Reset asserted during FILL1 with mem_req=1: mem_req=0 the same cycle. After release, a read of the same address misses (valid cleared).
